// File: rtl/unified_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_responder
// Description : Single-port word memory shared by instruction fetch and data
//               access. Each request is captured, held for WAIT_STATES wait
//               cycles, then completed with a one-cycle ack pulse. Addresses
//               at or beyond DEPTH complete with err and have no side effect.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err,
  output logic [15:0]       acc_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Index width covering exactly the implemented words.
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [3:0]        wait_cnt;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              in_range;
  logic [IDX_W-1:0]  mem_idx;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Range check is done on the full captured address, so aliasing through
  // the truncated index can never reach memory.
  assign in_range = (32'(cap_addr) < DEPTH);
  assign mem_idx  = cap_addr[IDX_W-1:0];

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: req is only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture the request on accept and count down the wait cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (state == ST_IDLE && req) begin
      wait_cnt  <= WAIT_INIT;
      cap_we    <= we;
      cap_addr  <= addr;
      cap_wdata <= wdata;
    end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Completed-transaction counter, stepped on every RESP to IDLE edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_count <= 16'd0;
    end else if (state == ST_RESP) begin
      acc_count <= acc_count + 16'd1;
    end
  end

  // Write commit on the RESP to IDLE edge; storage is never cleared, and a
  // reset forces state to IDLE asynchronously so an aborted write cannot land.
  always_ff @(posedge clock) begin
    if (state == ST_RESP && cap_we && in_range) begin
      mem[mem_idx] <= cap_wdata;
    end
  end

  // Outputs decoded from state; rdata is zero unless a valid read completes.
  always_comb begin
    ack   = 1'b0;
    busy  = 1'b0;
    err   = 1'b0;
    rdata = '0;
    case (state)
      ST_WAIT: busy = 1'b1;
      ST_RESP: begin
        busy = 1'b1;
        ack  = 1'b1;
        err  = !in_range;
        if (!cap_we && in_range) begin
          rdata = mem[mem_idx];
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_mem_responder
// Description : Directed bench. Instance a uses WAIT_STATES=2, DEPTH=128;
//               instance b uses WAIT_STATES=0, DEPTH=256.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_responder;

  logic        clock = 1'b0;
  logic        reset_a, req_a, we_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic        ack_a, busy_a, err_a;
  logic [15:0] cnt_a;

  logic        reset_b, req_b, we_b;
  logic [7:0]  addr_b;
  logic [31:0] wdata_b, rdata_b;
  logic        ack_b, busy_b, err_b;
  logic [15:0] cnt_b;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_cnt_a;

  always #5 clock = ~clock;

  unified_mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(128), .WAIT_STATES(2)) dut_a (
    .clock(clock), .reset(reset_a), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .err(err_a),
    .acc_count(cnt_a)
  );

  unified_mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) dut_b (
    .clock(clock), .reset(reset_b), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .err(err_b),
    .acc_count(cnt_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request to instance a for one accept edge, then drop req.
  task automatic issue_a(input logic w, input logic [7:0] a, input logic [31:0] d);
    req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
    tick();
    req_a = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    vectors++; if (ack_a !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", ack_a); end
    vectors++; if (err_a !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err_a); end
    vectors++; if (rdata_a !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata_a); end
    vectors++; if (cnt_a !== 16'h0) begin miscompares++; $display("FAIL reset_count: got %h want 0", cnt_a); end
    vectors++; if (cnt_b !== 16'h0 || ack_b !== 1'b0) begin miscompares++; $display("FAIL reset_b: got cnt %h ack %b want 0 0", cnt_b, ack_b); end
    reset_a = 1'b1;
    reset_b = 1'b1;
    exp_cnt_a = 16'd0;
  endtask

  task automatic test_write();
    issue_a(1'b1, 8'h10, 32'hDEADBEEF);
    for (int i = 1; i <= 4; i++) begin
      vectors++; if (busy_a !== (i <= 3)) begin miscompares++; $display("FAIL write_busy c%0d: got %b want %b", i, busy_a, (i <= 3)); end
      vectors++; if (ack_a !== (i == 3)) begin miscompares++; $display("FAIL write_ack c%0d: got %b want %b", i, ack_a, (i == 3)); end
      vectors++; if (rdata_a !== 32'h0) begin miscompares++; $display("FAIL write_rdata c%0d: got %h want 0", i, rdata_a); end
      if (i < 4) tick();
    end
    exp_cnt_a = exp_cnt_a + 16'd1;
    vectors++; if (cnt_a !== exp_cnt_a) begin miscompares++; $display("FAIL write_count: got %h want %h", cnt_a, exp_cnt_a); end
  endtask

  task automatic test_read();
    logic [31:0] exp_rd;
    issue_a(1'b0, 8'h10, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      exp_rd = (i == 3) ? 32'hDEADBEEF : 32'h0;
      vectors++; if (rdata_a !== exp_rd) begin miscompares++; $display("FAIL read_rdata c%0d: got %h want %h", i, rdata_a, exp_rd); end
      vectors++; if (ack_a !== (i == 3)) begin miscompares++; $display("FAIL read_ack c%0d: got %b want %b", i, ack_a, (i == 3)); end
      if (i < 4) tick();
    end
    exp_cnt_a = exp_cnt_a + 16'd1;
    vectors++; if (cnt_a !== exp_cnt_a) begin miscompares++; $display("FAIL read_count: got %h want %h", cnt_a, exp_cnt_a); end
  endtask

  task automatic test_out_of_range();
    issue_a(1'b0, 8'h90, 32'h0);
    tick(); tick();
    vectors++; if ({ack_a, err_a} !== 2'b11 || rdata_a !== 32'h0) begin miscompares++; $display("FAIL oor_read: got ack %b err %b rdata %h want 1 1 0", ack_a, err_a, rdata_a); end
    tick();
    issue_a(1'b1, 8'h90, 32'hCAFEF00D);
    tick(); tick();
    vectors++; if ({ack_a, err_a} !== 2'b11) begin miscompares++; $display("FAIL oor_write: got ack %b err %b want 1 1", ack_a, err_a); end
    tick();
    exp_cnt_a = exp_cnt_a + 16'd2;
    vectors++; if (cnt_a !== exp_cnt_a) begin miscompares++; $display("FAIL oor_count: got %h want %h", cnt_a, exp_cnt_a); end
    // 0x90 aliases 0x10 in the low index bits; it must be untouched.
    issue_a(1'b0, 8'h10, 32'h0);
    tick(); tick();
    vectors++; if (rdata_a !== 32'hDEADBEEF || err_a !== 1'b0) begin miscompares++; $display("FAIL oor_alias: got %h err %b want deadbeef 0", rdata_a, err_a); end
    tick();
    exp_cnt_a = exp_cnt_a + 16'd1;
  endtask

  task automatic test_reset_mid();
    issue_a(1'b1, 8'h05, 32'hA5A5A5A5);
    tick(); tick(); tick();
    issue_a(1'b1, 8'h05, 32'h12345678);
    #1 reset_a = 1'b0;
    #1;
    vectors++; if (busy_a !== 1'b0 || ack_a !== 1'b0) begin miscompares++; $display("FAIL rstmid_async: got busy %b ack %b want 0 0", busy_a, ack_a); end
    vectors++; if (cnt_a !== 16'h0) begin miscompares++; $display("FAIL rstmid_count: got %h want 0", cnt_a); end
    tick();
    vectors++; if (ack_a !== 1'b0 || cnt_a !== 16'h0) begin miscompares++; $display("FAIL rstmid_hold: got ack %b cnt %h want 0 0", ack_a, cnt_a); end
    reset_a = 1'b1;
    issue_a(1'b0, 8'h05, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      vectors++; if (ack_a !== (i == 3)) begin miscompares++; $display("FAIL rstmid_ack c%0d: got %b want %b", i, ack_a, (i == 3)); end
      if (i < 3) tick();
    end
    vectors++; if (rdata_a !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL rstmid_prior: got %h want a5a5a5a5", rdata_a); end
    tick();
    exp_cnt_a = 16'd1;
    vectors++; if (cnt_a !== exp_cnt_a) begin miscompares++; $display("FAIL rstmid_count2: got %h want %h", cnt_a, exp_cnt_a); end
  endtask

  task automatic test_captured();
    issue_a(1'b1, 8'h21, 32'h0BADF00D);
    tick(); tick(); tick();
    issue_a(1'b1, 8'h20, 32'h11112222);
    addr_a = 8'h21; wdata_a = 32'h99999999; we_a = 1'b0;
    tick(); tick();
    vectors++; if (ack_a !== 1'b1 || rdata_a !== 32'h0) begin miscompares++; $display("FAIL capt_ack: got ack %b rdata %h want 1 0", ack_a, rdata_a); end
    tick();
    issue_a(1'b0, 8'h20, 32'h0);
    tick(); tick();
    vectors++; if (rdata_a !== 32'h11112222) begin miscompares++; $display("FAIL capt_addr20: got %h want 11112222", rdata_a); end
    tick();
    issue_a(1'b0, 8'h21, 32'h0);
    tick(); tick();
    vectors++; if (rdata_a !== 32'h0BADF00D) begin miscompares++; $display("FAIL capt_addr21: got %h want 0badf00d", rdata_a); end
    tick();
    exp_cnt_a = exp_cnt_a + 16'd4;
    vectors++; if (cnt_a !== exp_cnt_a) begin miscompares++; $display("FAIL capt_count: got %h want %h", cnt_a, exp_cnt_a); end
  endtask

  task automatic test_held_req();
    req_a = 1'b1; we_a = 1'b0; addr_a = 8'h20; wdata_a = 32'h0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      vectors++; if (ack_a !== (i == 3 || i == 7)) begin miscompares++; $display("FAIL held_ack c%0d: got %b want %b", i, ack_a, (i == 3 || i == 7)); end
      vectors++; if (busy_a !== !(i == 4 || i == 8)) begin miscompares++; $display("FAIL held_busy c%0d: got %b want %b", i, busy_a, !(i == 4 || i == 8)); end
      if (i == 7) begin
        vectors++; if (rdata_a !== 32'h11112222) begin miscompares++; $display("FAIL held_rdata: got %h want 11112222", rdata_a); end
        req_a = 1'b0;
      end
      if (i < 8) tick();
    end
    exp_cnt_a = exp_cnt_a + 16'd2;
    vectors++; if (cnt_a !== exp_cnt_a) begin miscompares++; $display("FAIL held_count: got %h want %h", cnt_a, exp_cnt_a); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_c;
    req_b = 1'b1; we_b = 1'b1; addr_b = 8'h03; wdata_b = 32'h00000055;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_c = 16'((i + 1) / 2);
      vectors++; if (ack_b !== (i % 2 == 0) || busy_b !== (i % 2 == 0)) begin miscompares++; $display("FAIL b2b_ack c%0d: got ack %b busy %b want %b", i, ack_b, busy_b, (i % 2 == 0)); end
      vectors++; if (cnt_b !== exp_c) begin miscompares++; $display("FAIL b2b_count c%0d: got %h want %h", i, cnt_b, exp_c); end
    end
    we_b = 1'b0;
    tick();
    vectors++; if (ack_b !== 1'b1 || err_b !== 1'b0 || rdata_b !== 32'h55) begin miscompares++; $display("FAIL b2b_read: got ack %b err %b rdata %h want 1 0 55", ack_b, err_b, rdata_b); end
    req_b = 1'b0;
    tick();
    vectors++; if (ack_b !== 1'b0 || rdata_b !== 32'h0 || cnt_b !== 16'd5) begin miscompares++; $display("FAIL b2b_end: got ack %b rdata %h cnt %h want 0 0 5", ack_b, rdata_b, cnt_b); end
  endtask

  initial begin
    reset_a = 1'b0; req_a = 1'b0; we_a = 1'b0; addr_a = 8'h0; wdata_a = 32'h0;
    reset_b = 1'b0; req_b = 1'b0; we_b = 1'b0; addr_b = 8'h0; wdata_b = 32'h0;
    exp_cnt_a = 16'd0;
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_reset_mid();
    test_captured();
    test_held_req();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
